// File: rtl/elastic_buffer.sv
// Registered-output elastic buffer: a DEPTH-entry register FIFO with flags
// computed from the next occupancy, so no input reaches an output combinationally.
module elastic_buffer #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         s_valid,
  input  logic [WIDTH-1:0]             s_data,
  output logic                         s_ready,
  output logic                         m_valid,
  output logic [WIDTH-1:0]             m_data,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; valid never waits on ready, and ready/valid here are plain registers.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_m_valid;
  logic             r_s_ready;
  logic             r_almost_full;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_next;

  assign w_push = s_valid & r_s_ready;
  assign w_pop  = r_m_valid & m_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage is never reset; its contents only matter while m_valid is high.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_count       <= '0;
      r_m_valid     <= 1'b0;
      r_s_ready     <= 1'b1;
      r_almost_full <= 1'b0;
    end else begin
      r_count       <= w_count_next;
      r_m_valid     <= (w_count_next != '0);
      r_s_ready     <= (w_count_next != FULL_CNT);
      r_almost_full <= (w_count_next >= AF_CNT);
    end
  end

  assign m_data      = r_mem[r_rd_ptr];
  assign m_valid     = r_m_valid;
  assign s_ready     = r_s_ready;
  assign count       = r_count;
  assign almost_full = r_almost_full;

endmodule

// File: tb/tb_elastic_buffer.sv
// Directed and randomized checks of elastic_buffer at WIDTH=8, DEPTH=4, AF_LEVEL=3.
module tb_elastic_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic             clk;
  logic             rstn;
  logic             flush;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [2:0]       count;
  logic             almost_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];

  elastic_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b want 0", almost_full); end
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [2:0] e_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       e_af  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       e_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = vals[i];
      @(negedge clk);
      n_checks++; if (count !== e_cnt[i]) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, e_cnt[i]); end
      n_checks++; if (almost_full !== e_af[i]) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, e_af[i]); end
      n_checks++; if (s_ready !== e_rdy[i]) begin n_fail++; $display("FAIL fill_s_ready[%0d]: got %b want %b", i, s_ready, e_rdy[i]); end
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL fill_m_valid[%0d]: got %b want 1", i, m_valid); end
    end
    s_data = 8'h55;
    @(negedge clk);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_reject_count: got %0d want 4", count); end
    n_checks++; if (m_data !== 8'h11) begin n_fail++; $display("FAIL full_head: got %h want 11", m_data); end
  endtask

  task automatic test_drain();
    logic [7:0] e_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [2:0] e_cnt  [5] = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
    logic       e_rdy  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // 0x55 is still offered from the fill; it enters on the first cycle s_ready is back.
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL drain_m_valid[%0d]: got %b want 1", k, m_valid); end
      n_checks++; if (m_data !== e_data[k]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", k, m_data, e_data[k]); end
      n_checks++; if (count !== e_cnt[k]) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", k, count, e_cnt[k]); end
      n_checks++; if (s_ready !== e_rdy[k]) begin n_fail++; $display("FAIL drain_s_ready[%0d]: got %b want %b", k, s_ready, e_rdy[k]); end
      if (k == 2) s_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b want 0", m_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_empty_count: got %0d want 0", count); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL drain_empty_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    m_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      v = 8'h80 + 8'(j);
      s_valid = 1'b1; s_data = v;
      @(negedge clk);
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_m_valid[%0d]: got %b want 1", j, m_valid); end
      n_checks++; if (m_data !== v) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", j, m_data, v); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 1", j, count); end
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_s_ready[%0d]: got %b want 1", j, s_ready); end
    end
    s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_end_count: got %0d want 0", count); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hA1;
    @(negedge clk);
    s_data = 8'hA2;
    @(negedge clk);
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 2", count); end
    flush = 1'b1; s_data = 8'h99;
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_m_valid: got %b want 0", m_valid); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_s_ready: got %b want 1", s_ready); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL flush_af: got %b want 0", almost_full); end
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hold_valid: got %b want 0", m_valid); end
    s_valid = 1'b1; s_data = 8'h5A; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n_checks++; if (m_data !== 8'h5A) begin n_fail++; $display("FAIL flush_next_data: got %h want 5a", m_data); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL flush_next_count: got %0d want 1", count); end
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_final_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_random();
    logic             do_push;
    logic             do_pop;
    logic             stalled;
    logic [WIDTH-1:0] held;
    exp_q.delete();
    stalled = 1'b0; held = '0;
    for (int c = 0; c < 1000; c++) begin
      n_checks++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, exp_q.size()); end
      n_checks++; if (m_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_m_valid[%0d]: got %b want %b", c, m_valid, exp_q.size() != 0); end
      n_checks++; if (s_ready !== (exp_q.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_s_ready[%0d]: got %b want %b", c, s_ready, exp_q.size() != DEPTH); end
      n_checks++; if (almost_full !== (exp_q.size() >= AF)) begin n_fail++; $display("FAIL rnd_af[%0d]: got %b want %b", c, almost_full, exp_q.size() >= AF); end
      if (exp_q.size() != 0) begin
        n_checks++; if (m_data !== exp_q[0]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", c, m_data, exp_q[0]); end
      end
      if (stalled) begin
        n_checks++; if (m_data !== held) begin n_fail++; $display("FAIL rnd_stall_stable[%0d]: got %h want %h", c, m_data, held); end
      end
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom_range(0, 255));
      m_ready = 1'($urandom_range(0, 1));
      do_push = s_valid && (exp_q.size() != DEPTH);
      do_pop  = m_ready && (exp_q.size() != 0);
      stalled = (exp_q.size() != 0) && !m_ready;
      held    = (exp_q.size() != 0) ? exp_q[0] : '0;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(s_data);
      @(negedge clk);
    end
    s_valid = 1'b0; m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
